// File: rtl/ripemd160_chain_finalize.sv
// RIPEMD-160 multi-channel finaliser: folds left/right compression-line results into
// per-channel chaining values and emits the 160-bit digest on each message's last block.
module ripemd160_chain_finalize #(
  parameter int NUM_CH    = 4,
  parameter int CH_W      = 2,
  parameter bit DIGEST_LE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [CH_W-1:0]   i_ch,
  input  logic              i_first,
  input  logic              i_last,
  input  logic [159:0]      i_left,
  input  logic [159:0]      i_right,
  input  logic [CH_W-1:0]   cv_sel,
  output logic [159:0]      cv_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [CH_W-1:0]   o_ch,
  output logic [159:0]      o_digest,
  output logic [NUM_CH-1:0] o_busy,
  output logic              o_err
);

  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;

  logic [159:0] cv_q [NUM_CH];

  logic         accept;
  logic         ch_ok;
  logic         ch_busy;
  logic [159:0] ch_cv;
  logic         sel_busy;
  logic [159:0] sel_cv;
  logic [159:0] base;
  logic [31:0]  bw [5];
  logic [31:0]  lw [5];
  logic [31:0]  rw [5];
  logic [159:0] fold;
  logic [159:0] fold_out;

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign i_ready = ~o_valid | o_ready;
  assign accept  = i_valid & i_ready;

  // Channel lookups are done by compare loops so out-of-range indices simply miss.
  always_comb begin
    ch_cv    = IV;
    ch_busy  = 1'b0;
    ch_ok    = 1'b0;
    sel_cv   = IV;
    sel_busy = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(i_ch) == k) begin
        ch_cv   = cv_q[k];
        ch_busy = o_busy[k];
        ch_ok   = 1'b1;
      end
      if (int'(cv_sel) == k) begin
        sel_cv   = cv_q[k];
        sel_busy = o_busy[k];
      end
    end
  end

  assign cv_data = sel_busy ? sel_cv : IV;

  // An idle channel always starts from IV, even if the first flag was missing.
  assign base = (i_first | ~ch_busy) ? IV : ch_cv;

  always_comb begin
    for (int i = 0; i < 5; i++) begin
      bw[i] = base[159-32*i -: 32];
      lw[i] = i_left[159-32*i -: 32];
      rw[i] = i_right[159-32*i -: 32];
    end
  end

  assign fold = {bw[1] + lw[2] + rw[3],
                 bw[2] + lw[3] + rw[4],
                 bw[3] + lw[4] + rw[0],
                 bw[4] + lw[0] + rw[1],
                 bw[0] + lw[1] + rw[2]};

  always_comb begin
    fold_out = fold;
    if (DIGEST_LE) begin
      for (int i = 0; i < 5; i++) begin
        fold_out[32*i +: 32] = bswap(fold[32*i +: 32]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_ch     <= '0;
      o_digest <= '0;
      o_busy   <= '0;
      o_err    <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        cv_q[k] <= IV;
      end
    end else begin
      if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
      if (accept) begin
        if (!ch_ok) begin
          o_err <= 1'b1;
        end else begin
          if (i_first == ch_busy) begin
            o_err <= 1'b1;
          end
          for (int k = 0; k < NUM_CH; k++) begin
            if (int'(i_ch) == k) begin
              cv_q[k]   <= i_last ? IV : fold;
              o_busy[k] <= ~i_last;
            end
          end
          if (i_last) begin
            o_valid  <= 1'b1;
            o_ch     <= i_ch;
            o_digest <= fold_out;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ripemd160_chain_finalize.sv
// Self-checking bench for ripemd160_chain_finalize: constant vectors, stall/back-to-back
// sequences, random interleaved channels against a word-level model, errors and reset.
module tb_ripemd160_chain_finalize;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam logic [159:0] IV  = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] D1  = 160'hefcdab89_98badcfe_10325476_c3d2e1f0_67452301;
  localparam logic [159:0] D2  = 160'h98badcfe_10325476_c3d2e1f0_67452301_efcdab89;
  localparam logic [159:0] D1L = 160'h89abcdef_fedcba98_76543210_f0e1d2c3_01234567;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              i_valid = 1'b0;
  logic              i_ready;
  logic [CH_W-1:0]   i_ch = '0;
  logic              i_first = 1'b0;
  logic              i_last = 1'b0;
  logic [159:0]      i_left = '0;
  logic [159:0]      i_right = '0;
  logic [CH_W-1:0]   cv_sel = '0;
  logic [159:0]      cv_data;
  logic              o_valid;
  logic              o_ready = 1'b1;
  logic [CH_W-1:0]   o_ch;
  logic [159:0]      o_digest;
  logic [NUM_CH-1:0] o_busy;
  logic              o_err;

  logic              le_i_ready;
  logic [159:0]      le_cv_data;
  logic              le_o_valid;
  logic [CH_W-1:0]   le_o_ch;
  logic [159:0]      le_o_digest;
  logic [NUM_CH-1:0] le_o_busy;
  logic              le_o_err;
  logic              le_o_ready = 1'b1;

  int nComp = 0;
  int nFail = 0;
  int xferCnt = 0;

  logic [31:0] ivWords [5] = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};
  logic [31:0] mCv [NUM_CH][5];
  bit          mBusy [NUM_CH];
  bit          mErr;
  logic [159:0] expDigest;

  typedef struct {
    int           ch;
    bit           first;
    bit           last;
    logic [159:0] left;
    logic [159:0] right;
    bit           expValid;
    logic [159:0] expDigest;
    logic [3:0]   expBusy;
  } vec_t;

  vec_t vecs [3];

  ripemd160_chain_finalize #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIGEST_LE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_ch(i_ch),
    .i_first(i_first), .i_last(i_last), .i_left(i_left), .i_right(i_right),
    .cv_sel(cv_sel), .cv_data(cv_data), .o_valid(o_valid), .o_ready(o_ready),
    .o_ch(o_ch), .o_digest(o_digest), .o_busy(o_busy), .o_err(o_err)
  );

  ripemd160_chain_finalize #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DIGEST_LE(1'b1)) dut_le (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(le_i_ready), .i_ch(i_ch),
    .i_first(i_first), .i_last(i_last), .i_left(i_left), .i_right(i_right),
    .cv_sel(cv_sel), .cv_data(le_cv_data), .o_valid(le_o_valid), .o_ready(le_o_ready),
    .o_ch(le_o_ch), .o_digest(le_o_digest), .o_busy(le_o_busy), .o_err(le_o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && o_valid && o_ready) xferCnt++;
  end

  task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
    nComp++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < 5; i++) mCv[c][i] = ivWords[i];
      mBusy[c] = 1'b0;
    end
    mErr = 1'b0;
  endtask

  // Word-level model: new word i = base[i+1] + left[i+2] + right[i+3], indices mod 5.
  task automatic modelAccept(input int ch, input bit first, input bit last,
                             input logic [159:0] l, input logic [159:0] r);
    logic [31:0] b [5];
    logic [31:0] n [5];
    if (ch >= NUM_CH) begin
      mErr = 1'b1;
      return;
    end
    if (first == mBusy[ch]) mErr = 1'b1;
    for (int i = 0; i < 5; i++) b[i] = (first || !mBusy[ch]) ? ivWords[i] : mCv[ch][i];
    for (int i = 0; i < 5; i++)
      n[i] = b[(i+1)%5] + l[159-32*((i+2)%5) -: 32] + r[159-32*((i+3)%5) -: 32];
    if (last) begin
      for (int i = 0; i < 5; i++) begin
        expDigest[159-32*i -: 32] = n[i];
        mCv[ch][i] = ivWords[i];
      end
      mBusy[ch] = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) mCv[ch][i] = n[i];
      mBusy[ch] = 1'b1;
    end
  endtask

  function automatic logic [159:0] modelCv(input int ch);
    logic [159:0] v;
    for (int i = 0; i < 5; i++) v[159-32*i -: 32] = mCv[ch][i];
    return v;
  endfunction

  function automatic logic [159:0] rand160();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic applyStimulus(input int ch, input bit first, input bit last,
                               input logic [159:0] l, input logic [159:0] r);
    int waitCnt = 0;
    i_valid = 1'b1;
    i_ch    = CH_W'(ch);
    i_first = first;
    i_last  = last;
    i_left  = l;
    i_right = r;
    while (!i_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!i_ready) begin
      nComp++;
      nFail++;
      $display("[TB] FAIL accept_timeout: i_ready got 0 expected 1");
    end
    @(posedge clk);
    modelAccept(ch, first, last, l, r);
    #1 i_valid = 1'b0;
  endtask

  task automatic runRandomMessages(input int chA, input int chB);
    logic [159:0] digA;
    for (int blk = 0; blk < 3; blk++) begin
      applyStimulus(chA, blk == 0, blk == 2, rand160(), rand160());
      digA = expDigest;
      if (blk == 1) begin
        @(negedge clk);
        cv_sel = CH_W'(chA);
        #1 checkOutput("rand_cv_data", cv_data, modelCv(chA));
      end
      applyStimulus(chB, blk == 0, blk == 2, rand160(), rand160());
      if (blk == 2) begin
        @(negedge clk);
        checkOutput("rand_digest_b", o_digest, expDigest);
        checkOutput("rand_ch_b", 160'(o_ch), 160'(chB));
        checkOutput("rand_last_digest_a_xfer", 160'(o_valid), 160'(1));
      end
    end
    checkOutput("rand_model_digest_a_nonstale", 160'(digA == expDigest), 160'(0));
  endtask

  initial begin
    int c0;
    vecs[0] = '{0, 1'b1, 1'b1, 160'h0, 160'h0, 1'b1, D1, 4'b0000};
    vecs[1] = '{1, 1'b1, 1'b0, 160'h0, 160'h0, 1'b0, 160'h0, 4'b0010};
    vecs[2] = '{1, 1'b0, 1'b1, 160'h0, 160'h0, 1'b1, D2, 4'b0000};

    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 160'(o_valid), 160'(0));
    checkOutput("rst_digest", o_digest, 160'h0);
    checkOutput("rst_busy", 160'(o_busy), 160'(0));
    checkOutput("rst_err", 160'(o_err), 160'(0));
    checkOutput("rst_cv_data", cv_data, IV);
    rst_n = 1'b1;
    @(negedge clk);

    // Constant vectors: single-block message and a two-block message on ch1.
    for (int v = 0; v < 3; v++) begin
      applyStimulus(vecs[v].ch, vecs[v].first, vecs[v].last, vecs[v].left, vecs[v].right);
      @(negedge clk);
      checkOutput("vec_valid", 160'(o_valid), 160'(vecs[v].expValid));
      checkOutput("vec_busy", 160'(o_busy), 160'(vecs[v].expBusy));
      if (vecs[v].expValid) begin
        checkOutput("vec_digest", o_digest, vecs[v].expDigest);
        checkOutput("vec_ch", 160'(o_ch), 160'(vecs[v].ch));
      end
      if (v == 0) checkOutput("le_digest", le_o_digest, D1L);
    end
    checkOutput("vec_err", 160'(o_err), 160'(0));

    // Downstream stall holds the digest and blocks input for 5 cycles.
    @(negedge clk);
    o_ready = 1'b0;
    c0 = xferCnt;
    applyStimulus(0, 1'b1, 1'b1, 160'h0, 160'h0);
    i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_valid", 160'(o_valid), 160'(1));
      checkOutput("stall_iready", 160'(i_ready), 160'(0));
      checkOutput("stall_digest", o_digest, D1);
      checkOutput("stall_busy", 160'(o_busy), 160'(0));
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_drain", 160'(o_valid), 160'(0));
    @(negedge clk);
    checkOutput("stall_xfers", 160'(xferCnt - c0), 160'(1));

    // Back-to-back last blocks keep o_valid high with the newer result.
    c0 = xferCnt;
    applyStimulus(0, 1'b1, 1'b1, 160'h0, 160'h0);
    applyStimulus(3, 1'b1, 1'b1, 160'h0, 160'h0);
    @(negedge clk);
    checkOutput("b2b_valid", 160'(o_valid), 160'(1));
    checkOutput("b2b_ch", 160'(o_ch), 160'(3));
    checkOutput("b2b_digest", o_digest, D1);
    @(negedge clk);
    checkOutput("b2b_xfers", 160'(xferCnt - c0), 160'(2));

    for (int round = 0; round < 3; round++) runRandomMessages(0, 2);
    @(negedge clk);
    checkOutput("rand_err", 160'(o_err), 160'(0));

    // Missing first flag on idle ch3 flags an error and still uses IV.
    applyStimulus(3, 1'b0, 1'b1, rand160(), rand160());
    @(negedge clk);
    checkOutput("nofirst_err", 160'(o_err), 160'(mErr));
    checkOutput("nofirst_digest", o_digest, expDigest);

    // Restart on a busy channel discards the old message.
    applyStimulus(2, 1'b1, 1'b0, rand160(), rand160());
    applyStimulus(2, 1'b1, 1'b0, rand160(), rand160());
    applyStimulus(2, 1'b0, 1'b1, rand160(), rand160());
    @(negedge clk);
    checkOutput("restart_digest", o_digest, expDigest);

    // Asynchronous reset mid-message.
    applyStimulus(1, 1'b1, 1'b0, rand160(), rand160());
    @(negedge clk);
    cv_sel = CH_W'(1);
    #1 checkOutput("pre_rst_cv", cv_data, modelCv(1));
    checkOutput("pre_rst_busy", 160'(o_busy), 160'(4'b0010));
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_busy", 160'(o_busy), 160'(0));
    checkOutput("mid_rst_err", 160'(o_err), 160'(0));
    checkOutput("mid_rst_cv", cv_data, IV);
    checkOutput("mid_rst_valid", 160'(o_valid), 160'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b1, 160'h0, 160'h0);
    @(negedge clk);
    checkOutput("post_rst_digest", o_digest, D1);
    checkOutput("post_rst_err", 160'(o_err), 160'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
    $finish;
  end

endmodule
